// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame geometry, receiver FSM states and the
// inter-edge timeout default shared by the receive and host-transmit blocks.
package ps2_pkg;

    localparam int unsigned PS2_DATA_BITS      = 8;
    localparam int unsigned PS2_FRAME_BITS     = 11;
    localparam int unsigned PS2_TIMEOUT_CYCLES = 100000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic ps2_odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d,
                                               input logic                     p);
        return (^d) ^ p;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 lines, deglitches the clock line and emits a
// one-cycle pulse on each filtered clock falling edge.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_s,
    output logic fall
);

    localparam int unsigned FLT_W = $clog2(FILTER_LEN);

    logic [1:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             filt_q, filt_d;
    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic             fall_q, fall_d;

    // The filtered level flips only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                flt_cnt_d = flt_cnt_q + FLT_W'(1);
            end
        end
        fall_d = filt_q & ~filt_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            flt_cnt_q   <= '0;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            filt_q      <= filt_d;
            flt_cnt_q   <= flt_cnt_d;
            fall_q      <= fall_d;
        end
    end

    assign data_s = data_sync_q[1];
    assign fall   = fall_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: deserialises start/8 data/odd parity/stop
// frames and strobes each good byte, or a parity/frame error, for one cycle.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    output logic [PS2_DATA_BITS-1:0] rx_byte,
    output logic                     rx_valid,
    output logic                     parity_err,
    output logic                     frame_err
);

    localparam int unsigned CNT_W = $clog2(PS2_DATA_BITS);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    // Timer reads 0 in the cycle after a fall; firing at this value puts the
    // registered frame_err exactly TIMEOUT_CYCLES cycles after the fall pulse.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);

    logic data_s;
    logic fall;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .clk      (clk),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_s   (data_s),
        .fall     (fall)
    );

    ps2_state_e               state_q, state_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [PS2_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                     par_q, par_d;
    logic [TMO_W-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic [PS2_DATA_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                     rx_valid_q, rx_valid_d;
    logic                     parity_err_q, parity_err_d;
    logic                     frame_err_q, frame_err_d;
    logic                     timeout_c;

    // A fall in the same cycle as the timeout wins.
    assign timeout_c = (state_q != ST_IDLE) && !fall && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        rx_byte_d    = rx_byte_q;
        rx_valid_d   = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        tmo_cnt_d    = (state_q == ST_IDLE || fall) ? '0 : tmo_cnt_q + TMO_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (fall && !data_s) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shreg_d = {data_s, shreg_q[PS2_DATA_BITS-1:1]};
                    if (bit_cnt_q == CNT_W'(PS2_DATA_BITS - 1)) begin
                        state_d   = ST_PARITY;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_d   = data_s;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    if (!data_s) begin
                        frame_err_d = 1'b1;
                    end else if (ps2_odd_parity_ok(shreg_q, par_q)) begin
                        rx_byte_d  = shreg_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        parity_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout_c) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            tmo_cnt_q    <= '0;
            rx_byte_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            tmo_cnt_q    <= tmo_cnt_d;
            rx_byte_q    <= rx_byte_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_byte    = rx_byte_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: directed and random PS/2 frames checked against a
// frame-level model of the expected strobe, byte and strobe timing.
module tb_ps2_rx;
    import ps2_pkg::*;

    localparam int unsigned FL   = 4;
    localparam int unsigned TMO  = 300;
    localparam int unsigned HALF = 40;

    localparam int K_VALID = 1;
    localparam int K_PERR  = 2;
    localparam int K_FERR  = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;

    ps2_rx #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_fall = 0;
    int obs_k[$], obs_b[$], obs_c[$];
    int exp_k[$], exp_b[$], exp_c[$];
    logic [7:0] model_byte;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Frame-level reference: stop bit first, then odd parity over data + parity.
    function automatic int model_kind(input logic [7:0] d, input logic p, input logic s);
        if (!s) return K_FERR;
        if ((($countones(d) + int'(p)) % 2) == 1) return K_VALID;
        return K_PERR;
    endfunction

    // Record every strobe with the clock edge count at which it became visible.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rx_valid || parity_err || frame_err) begin
                check("onehot", 32'(rx_valid) + 32'(parity_err) + 32'(frame_err), 1);
                obs_k.push_back(rx_valid ? K_VALID : (parity_err ? K_PERR : K_FERR));
                obs_b.push_back(int'(rx_byte));
                obs_c.push_back(cyc);
            end
        end
    end

    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            repeat (HALF / 2) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (2) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF - HALF / 2 - 2) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_clk   = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit glitch);
        logic [PS2_FRAME_BITS-1:0] f;
        int k;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < PS2_FRAME_BITS; i++) ps2_bit(f[i], glitch);
        k = model_kind(d, p, s);
        exp_k.push_back(k);
        exp_b.push_back(int'(d));
        // 2 sync + FL filter cycles to the fall pulse, +1 for the registered strobe.
        exp_c.push_back(last_fall + 3 + int'(FL));
        if (k == K_VALID) model_byte = d;
    endtask

    task automatic settle(input string tag);
        int n;
        repeat (20) @(negedge clk);
        check($sformatf("%s.count", tag), obs_k.size(), exp_k.size());
        n = (obs_k.size() < exp_k.size()) ? obs_k.size() : exp_k.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.kind%0d", tag, i), obs_k[i], exp_k[i]);
            check($sformatf("%s.cycle%0d", tag, i), obs_c[i], exp_c[i]);
            if (exp_k[i] == K_VALID)
                check($sformatf("%s.byte%0d", tag, i), obs_b[i], exp_b[i]);
        end
        check($sformatf("%s.rx_byte", tag), rx_byte, model_byte);
        obs_k.delete(); obs_b.delete(); obs_c.delete();
        exp_k.delete(); exp_b.delete(); exp_c.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s.rx_byte", tag), rx_byte, 0);
        check($sformatf("%s.rx_valid", tag), rx_valid, 0);
        check($sformatf("%s.parity_err", tag), parity_err, 0);
        check($sformatf("%s.frame_err", tag), frame_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic       p;
        logic       s;
        int         r;
        int         t0;

        model_byte = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        send_frame(8'h08, 1'b0, 1'b1, 1'b0);
        settle("single08");

        send_frame(8'h08, 1'b0, 1'b1, 1'b0);
        send_frame(8'h12, 1'b1, 1'b1, 1'b0);
        send_frame(8'h34, 1'b0, 1'b1, 1'b0);
        settle("b2b");

        send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
        settle("parity_bad");

        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        settle("stop_bad");

        // Start plus five data bits, then the lines stay idle high.
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
        t0 = last_fall;
        exp_k.push_back(K_FERR);
        exp_b.push_back(0);
        exp_c.push_back(t0 + 2 + int'(FL) + int'(TMO));
        repeat (TMO + 50) @(negedge clk);
        settle("timeout");

        send_frame(8'h55, 1'b1, 1'b1, 1'b0);
        settle("after_timeout");

        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        settle("glitch");

        // Reset pulsed partway through a frame.
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("mid_reset");
        model_byte = 8'h00;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        settle("post_reset");

        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        settle("after_reset");

        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom_range(0, 255));
            r = int'($urandom_range(0, 9));
            p = ~(^d);
            s = 1'b1;
            if (r == 0) p = ~p;
            if (r == 1) s = 1'b0;
            send_frame(d, p, s, $urandom_range(0, 3) == 0);
            settle($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

PS/2 device-to-host serial receiver. It synchronises and deglitches the raw `ps2_clk`/`ps2_data` lines and deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop). Each good byte is delivered as a one-cycle strobe. It sits directly upstream of the PS/2 packet framer, which consumes `rx_byte` on every `rx_valid`.

## Interface
- `FILTER_LEN`, default 4: consecutive identical samples required before the filtered `ps2_clk` level changes (range 2–15).
- `TIMEOUT_CYCLES`, default 100000: `clk` cycles allowed between falling edges inside a frame before it is aborted (2 ms at 50 MHz).
- `clk`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock line, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data line, asynchronous to `clk`.
- `rx_byte`  out  8  last correctly received byte; held until the next good frame.
- `rx_valid`  out  1  one-cycle pulse; `rx_byte` is new and valid in the same cycle.
- `parity_err`  out  1  one-cycle pulse: frame had a valid stop bit but even parity; byte discarded.
- `frame_err`  out  1  one-cycle pulse: stop bit was 0, or timeout mid-frame; byte discarded.

## Operation
- Both lines pass through a 2-FF synchroniser. Synchronised `ps2_clk` feeds a saturating glitch filter whose filtered level resets to 1.
- A sample event (`fall`) is one `clk` cycle, generated when the filtered clock goes 1→0. Synchronised data is sampled in that cycle.
- FSM states are IDLE, DATA, PARITY, STOP. Reset state is IDLE.
- IDLE: on `fall`, if data=0, go to DATA with bit count 0. If data=1, stay in IDLE (spurious edge, no error).
- DATA: on each `fall`, shift right: `shreg <= {d, shreg[7:1]}`. After the 8th bit (count 7), go to PARITY.
- PARITY: on `fall`, capture the parity bit and go to STOP.
- STOP: on `fall`, check the stop bit and parity, then return to IDLE. Odd parity is good when `^shreg ^ p == 1`.
  - Stop=1 and parity good: load `rx_byte` and pulse `rx_valid`.
  - Stop=1 and parity bad: pulse `parity_err`.
  - Stop=0: pulse `frame_err`. This takes priority over a parity result.
- Timeout: a cycle counter clears on every `fall` and in IDLE. In any other state, reaching `TIMEOUT_CYCLES` pulses `frame_err`, forces IDLE and clears the bit count.
- A `fall` in the same cycle as the timeout: the `fall` wins and the counter clears.
- At most one of `rx_valid`, `parity_err`, `frame_err` is high in any cycle.
- Back-to-back frames are supported with no dead time. The state returns to IDLE in the cycle after the stop sample.

## Timing
- Reset values while `reset_n`=0:
  - `rx_byte`=8'h00; `rx_valid`, `parity_err`, `frame_err`=0.
  - State IDLE, bit count 0, timeout counter 0.
  - Synchroniser FFs and filtered clock =1.
- Reset asserted mid-frame discards the partial byte, and no error pulse is produced. The first `fall` after reset release must be a start bit to be accepted.
- Edge latency: from a raw `ps2_clk` fall to `fall` is 2 (sync) + `FILTER_LEN` cycles.
- Output latency: all outputs are registered. `rx_valid` or an error pulse is asserted in the cycle after the stop-bit `fall`.
- Glitches on `ps2_clk` shorter than `FILTER_LEN` cycles produce no `fall`.
- `ps2_data` is not filtered. It is sampled 2+`FILTER_LEN` cycles after the raw edge, which is well inside the PS/2 data-stable window (≥5 µs).

## Structure
- Shared package `ps2_pkg` holds:
  - the state enum (IDLE/DATA/PARITY/STOP);
  - `PS2_DATA_BITS`=8 and `PS2_FRAME_BITS`=11;
  - the default `TIMEOUT_CYCLES` constant, which is shared with the host-transmit block.
- Sub-module `ps2_line_filter`: 2-FF synchroniser for both lines, `ps2_clk` glitch filter, and falling-edge pulse generator. Outputs `data_s` and `fall`.
- `ps2_rx` top holds the FSM, shift register, bit counter, timeout counter and output registers.

## Test plan
- Frame 0x08, parity 0, stop 1 at a 12.5 kHz PS/2 clock → exactly one `rx_valid` with `rx_byte`=8'h08; no error pulses.
- Back-to-back frames 0x08, 0x12, 0x34 (parity 0, 1, 0) → three `rx_valid` pulses in order with matching `rx_byte`; state returns to IDLE between frames.
- Frame 0xFF with parity 0 → one `parity_err` pulse, no `rx_valid`, `rx_byte` unchanged.
- Frame 0x00 with parity 1 and stop 0 → one `frame_err` pulse, no `parity_err`, no `rx_valid`.
- Start plus 5 data bits, then lines idle high → `frame_err` exactly `TIMEOUT_CYCLES` cycles after the 6th `fall`. A following good 0x55 frame is then received correctly.
- Robustness and reset:
  - 2-cycle low glitches on `ps2_clk` (with `FILTER_LEN`=4) injected between bits of frame 0xA5 → `rx_byte`=8'hA5 received.
  - `reset_n` pulsed low after bit 4 of a frame → all outputs 0 and no pulses. The next full frame 0x3C is received correctly.
